// File: rtl/snake_hs_pkg.sv
// Shared definitions for the snake high-score path: controller states,
// score width default and the scroll-timer step size.
package snake_hs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    COMMIT,
    SCROLL,
    HOLD
  } hs_state_e;

  localparam int unsigned SCORE_W_DEF = 16;

  // Increment the decimal scroll timer adds on each of its step counts.
  localparam int unsigned SCROLL_STEP = 100000;

  // Clamp a raw scroll-timer value to the scroll limit.
  function automatic logic [31:0] sat_scroll(input logic [31:0] val,
                                             input logic [31:0] lim);
    return (val >= lim) ? lim : val;
  endfunction

endpackage

// File: rtl/hs_hold_counter.sv
// Frame-tick counter for the banner hold phase. Counts ticks while enabled
// and flags the tick that completes HOLD_FRAMES. It then restarts from zero,
// so it never wraps past HOLD_FRAMES.
module hs_hold_counter #(
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_done
);

  localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_FRAMES - 1);

  logic [CNT_W-1:0] r_hold_cnt;

  assign o_done = i_tick && (r_hold_cnt == LAST);

  // Count ticks, restarting on clear or when the final tick arrives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
    end else if (i_clr || o_done) begin
      r_hold_cnt <= '0;
    end else if (i_tick) begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/highscore_ctrl.sv
// Game-over sequencer for the high-score path.
// Sequence: capture score, compare it with the record, commit a new record,
// drive the scroll timer for the banner, hold the banner for a number of
// frames, then release the timer. Clear requests that arrive while busy are
// deferred to the first idle cycle. Game-overs that arrive while busy are
// ignored and latched as a sticky overrun.
module highscore_ctrl
  import snake_hs_pkg::*;
#(
  parameter int unsigned SCORE_W      = SCORE_W_DEF,
  parameter logic [31:0] SCROLL_LIMIT = 32'd400000,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  input  logic               clear_hs,
  input  logic               frame_tick,
  input  logic [31:0]        shift_val,
  output logic               timer_en,
  output logic [31:0]        scroll_pos,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record,
  output logic               show_banner,
  output logic               busy,
  output logic               overrun
);

  hs_state_e          r_state;
  logic [SCORE_W-1:0] r_score_q;
  logic [SCORE_W-1:0] r_high_score;
  logic [31:0]        r_scroll_pos;
  logic               r_new_record;
  logic               r_overrun;
  logic               r_clr_pend;
  logic               r_timer_en;
  logic               r_show_banner;
  logic               r_busy;

  logic               w_hold_tick;
  logic               w_hold_clr;
  logic               w_hold_done;

  assign w_hold_tick = frame_tick && (r_state == HOLD);
  assign w_hold_clr  = (r_state != HOLD);

  hs_hold_counter #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_hold_counter (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_hold_clr),
    .i_tick  (w_hold_tick),
    .o_done  (w_hold_done)
  );

  // Sequencer state plus every registered output, updated together on each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_score_q     <= '0;
      r_high_score  <= '0;
      r_scroll_pos  <= '0;
      r_new_record  <= 1'b0;
      r_overrun     <= 1'b0;
      r_clr_pend    <= 1'b0;
      r_timer_en    <= 1'b0;
      r_show_banner <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        if (game_over) begin
          r_overrun <= 1'b1;
        end
        if (clear_hs) begin
          r_clr_pend <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (clear_hs || r_clr_pend) begin
            r_high_score <= '0;
            r_clr_pend   <= 1'b0;
          end
          if (game_over) begin
            r_score_q    <= score;
            r_new_record <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= COMPARE;
          end
        end

        COMPARE: begin
          if (r_score_q > r_high_score) begin
            r_state <= COMMIT;
          end else begin
            r_timer_en    <= 1'b1;
            r_show_banner <= 1'b1;
            r_state       <= SCROLL;
          end
        end

        COMMIT: begin
          r_high_score  <= r_score_q;
          r_new_record  <= 1'b1;
          r_timer_en    <= 1'b1;
          r_show_banner <= 1'b1;
          r_state       <= SCROLL;
        end

        SCROLL: begin
          r_scroll_pos <= sat_scroll(shift_val, SCROLL_LIMIT);
          if (shift_val >= SCROLL_LIMIT) begin
            r_state <= HOLD;
          end
        end

        HOLD: begin
          if (w_hold_done) begin
            r_scroll_pos  <= '0;
            r_timer_en    <= 1'b0;
            r_show_banner <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_scroll_pos <= SCROLL_LIMIT;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign timer_en    = r_timer_en;
  assign scroll_pos  = r_scroll_pos;
  assign high_score  = r_high_score;
  assign new_record  = r_new_record;
  assign show_banner = r_show_banner;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule
